// File: rtl/adc_dc_remover_pkg.sv
// Shared definitions for the ADC front-end signal chain (DC remover, autocorrelation).
// Holds the estimator state type, default widths and a saturating subtract helper.
package signal_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_LOG2_WIN   = 10;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } dc_state_e;

  // Unsigned a - b clipped to the signed range of 'width' bits.
  function automatic int sat_sub(input logic [15:0] a, input logic [15:0] b, input int width);
    int diff;
    int hi;
    int lo;
    diff = int'(a) - int'(b);
    hi   = (1 << (width - 1)) - 1;
    lo   = -(1 << (width - 1));
    if (diff > hi) begin
      return hi;
    end
    if (diff < lo) begin
      return lo;
    end
    return diff;
  endfunction

  function automatic logic sub_clips(input logic [15:0] a, input logic [15:0] b, input int width);
    int diff;
    diff = int'(a) - int'(b);
    return (diff > ((1 << (width - 1)) - 1)) || (diff < -(1 << (width - 1)));
  endfunction

endpackage

// File: rtl/adc_dc_remover_if.sv
// Sample stream bus between the ADC front end, the DC remover and its consumer.
interface adc_dc_remover_if import signal_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  en;
  logic [DATA_WIDTH-1:0] dc_offset;
  logic                  sat;

  modport master (
    output sample_valid, adc_data, clear,
    input  data_out, out_valid, en, dc_offset, sat
  );

  modport slave (
    input  sample_valid, adc_data, clear,
    output data_out, out_valid, en, dc_offset, sat
  );
endinterface

// File: rtl/adc_dc_remover_window_mean.sv
// Sums non-overlapping windows of 2^LOG2_WIN samples and publishes each window mean.
// The window-closing sample is folded into the sum in the same edge that clears it.
module window_mean_acc import signal_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_WIN   = DEF_LOG2_WIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [DATA_WIDTH-1:0] mean,
  output logic                  mean_valid
);
  localparam int ACC_WIDTH = DATA_WIDTH + LOG2_WIN;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic [LOG2_WIN-1:0]  count;
  logic                 window_end;

  assign sum        = acc + ACC_WIDTH'(adc_data);
  assign window_end = sample_valid && (count == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      count      <= '0;
      mean       <= '0;
      mean_valid <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      count      <= '0;
      mean       <= '0;
      mean_valid <= 1'b0;
    end else begin
      mean_valid <= window_end;
      if (window_end) begin
        acc   <= '0;
        count <= '0;
        mean  <= sum[ACC_WIDTH-1:LOG2_WIN];
      end else if (sample_valid) begin
        acc   <= sum;
        count <= count + LOG2_WIN'(1);
      end
    end
  end

endmodule

// File: rtl/adc_dc_remover.sv
// Streaming DC-offset remover: subtracts the latest window mean from each ADC sample
// and emits a saturated, signed, zero-centred sample one clock after its strobe.
module adc_dc_remover import signal_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_WIN   = DEF_LOG2_WIN
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_dc_remover_if.slave  bus
);
  logic [DATA_WIDTH-1:0] mean;
  logic                  mean_valid;
  logic [DATA_WIDTH-1:0] diff_value;
  logic                  diff_clip;
  dc_state_e             state;
  dc_state_e             state_next;

  window_mean_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_WIN   (LOG2_WIN)
  ) u_window_mean (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (bus.clear),
    .sample_valid (bus.sample_valid),
    .adc_data     (bus.adc_data),
    .mean         (mean),
    .mean_valid   (mean_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WARMUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = WARMUP;
    end else if (state == WARMUP && mean_valid) begin
      state_next = RUN;
    end
  end

  // The mean register is zero until the first window closes, so WARMUP subtracts nothing.
  assign diff_value    = DATA_WIDTH'(sat_sub(16'(bus.adc_data), 16'(mean), DATA_WIDTH));
  assign diff_clip     = sub_clips(16'(bus.adc_data), 16'(mean), DATA_WIDTH);
  assign bus.en        = (state == RUN);
  assign bus.dc_offset = mean;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.sat       <= 1'b0;
    end else if (bus.clear) begin
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.sat       <= 1'b0;
    end else begin
      bus.out_valid <= bus.sample_valid;
      bus.sat       <= bus.sample_valid && diff_clip;
      if (bus.sample_valid) begin
        bus.data_out <= diff_value;
      end
    end
  end

endmodule

// File: tb/tb_adc_dc_remover.sv
// Directed scoreboard bench for adc_dc_remover: a window-mean model predicts every
// output sample, plus point checks on en / dc_offset around window and reset events.
module tb_adc_dc_remover;
  import signal_pkg::*;

  localparam int DW  = DEF_DATA_WIDTH;
  localparam int LW  = DEF_LOG2_WIN;
  localparam int WIN = 1 << LW;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t          exp_q[$];
  int            test_count = 0;
  int            fail_count = 0;
  int            in_count   = 0;
  int            out_count  = 0;
  int            m_acc      = 0;
  int            m_cnt      = 0;
  int            m_off      = 0;
  logic [DW-1:0] m_last     = '0;

  adc_dc_remover_if #(.DATA_WIDTH(DW)) bus ();

  adc_dc_remover #(
    .DATA_WIDTH (DW),
    .LOG2_WIN   (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model: mean of each closed window applies from the next sample on.
  task automatic model_push(input logic [DW-1:0] data);
    int   diff;
    logic s;
    diff = int'(data) - m_off;
    s    = 1'b0;
    if (diff > (1 << (DW - 1)) - 1) begin
      diff = (1 << (DW - 1)) - 1;
      s    = 1'b1;
    end else if (diff < -(1 << (DW - 1))) begin
      diff = -(1 << (DW - 1));
      s    = 1'b1;
    end
    exp_q.push_back('{DW'(diff), s});
    m_last = DW'(diff);
    in_count++;
    if (m_cnt == WIN - 1) begin
      m_off = (m_acc + int'(data)) >> LW;
      m_acc = 0;
      m_cnt = 0;
    end else begin
      m_acc = m_acc + int'(data);
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_off  = 0;
    m_last = '0;
    exp_q.delete();
    in_count  = 0;
    out_count = 0;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.out_valid === 1'b1) begin
      checkOutput("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("data_out", 32'(bus.data_out), 32'(e.data));
        checkOutput("sat", 32'(bus.sat), 32'(e.sat));
        out_count++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input int idle);
    bus.sample_valid = 1'b1;
    bus.adc_data     = data;
    model_push(data);
    tick();
    bus.sample_valid = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    bus.adc_data     = '0;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    bus.adc_data     = '0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", 32'(bus.data_out), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_en", 32'(bus.en), 32'd0);
    checkOutput("reset_dc_offset", 32'(bus.dc_offset), 32'd0);
    checkOutput("reset_sat", 32'(bus.sat), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Constant mid-scale input: en rises one cycle after the 1024th output.
    for (int i = 0; i < WIN - 1; i++) applyStimulus(12'd2048, 0);
    checkOutput("t1_en_before_last", 32'(bus.en), 32'd0);
    applyStimulus(12'd2048, 0);
    checkOutput("t1_en_at_last_out", 32'(bus.en), 32'd0);
    tick();
    checkOutput("t1_en_after", 32'(bus.en), 32'd1);
    checkOutput("t1_dc_offset", 32'(bus.dc_offset), 32'd2048);
    for (int i = 0; i < 8; i++) applyStimulus(12'd2048, 1);

    // Square wave 1000/3000, period 64 samples, one strobe per 20 clocks.
    do_reset();
    for (int i = 0; i < 3 * WIN; i++) begin
      applyStimulus(((i / 32) % 2 == 1) ? 12'd3000 : 12'd1000, 19);
      if (i % 256 == 100) checkOutput("t2_hold", 32'(bus.data_out), 32'(m_last));
      if (i == WIN - 1) checkOutput("t2_dc_offset_w1", 32'(bus.dc_offset), 32'd2000);
    end
    checkOutput("t2_dc_offset_end", 32'(bus.dc_offset), 32'd2000);
    checkOutput("t2_out_count", 32'(out_count), 32'(in_count));
    checkOutput("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero window then full scale: clipping until the new mean catches up.
    do_reset();
    for (int i = 0; i < WIN; i++) applyStimulus(12'd0, 0);
    applyStimulus(12'd4095, 0);
    checkOutput("t3_sat_flag", 32'(bus.sat), 32'd1);
    checkOutput("t3_clip_value", 32'(bus.data_out), 32'd2047);
    for (int i = 1; i < WIN; i++) applyStimulus(12'd4095, 0);
    checkOutput("t3_dc_offset", 32'(bus.dc_offset), 32'd4095);
    for (int i = 0; i < 16; i++) applyStimulus(12'd4095, 0);

    // Back-to-back ramp 0..2047.
    do_reset();
    for (int i = 0; i < 2 * WIN; i++) begin
      applyStimulus(DW'(i), 0);
      if (i == WIN - 1) checkOutput("t4_mean_w1", 32'(bus.dc_offset), 32'd511);
    end
    checkOutput("t4_mean_w2", 32'(bus.dc_offset), 32'd1535);
    checkOutput("t4_out_count", 32'(out_count), 32'(in_count));

    // Asynchronous reset at sample 700 discards the partial window.
    do_reset();
    for (int i = 0; i < 700; i++) applyStimulus(12'd3000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_data_out", 32'(bus.data_out), 32'd0);
    checkOutput("t5_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_sat", 32'(bus.sat), 32'd0);
    checkOutput("t5_en", 32'(bus.en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < WIN - 1; i++) applyStimulus(12'd1000, 0);
    checkOutput("t5_en_still_low", 32'(bus.en), 32'd0);
    applyStimulus(12'd1000, 0);
    tick();
    checkOutput("t5_en_high", 32'(bus.en), 32'd1);
    checkOutput("t5_dc_offset", 32'(bus.dc_offset), 32'd1000);

    // clear on the same edge as a strobe during RUN.
    applyStimulus(12'd1200, 0);
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.adc_data     = 12'd1500;
    model_reset();
    tick();
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_en", 32'(bus.en), 32'd0);
    checkOutput("t6_dc_offset", 32'(bus.dc_offset), 32'd0);
    checkOutput("t6_data_out", 32'(bus.data_out), 32'd0);
    for (int i = 0; i < WIN - 1; i++) applyStimulus(12'd600, 0);
    checkOutput("t6_en_still_low", 32'(bus.en), 32'd0);
    applyStimulus(12'd600, 0);
    tick();
    checkOutput("t6_en_high", 32'(bus.en), 32'd1);
    checkOutput("t6_dc_offset_new", 32'(bus.dc_offset), 32'd600);
    for (int i = 0; i < 4; i++) applyStimulus(12'd600, 2);
    checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
